// File: rtl/mult2_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mult2_stage                                                   |
// | Purpose  : Second stage of the integer multiply pipeline. Combines the   |
// |            registered partial products into the low 32 bits of the      |
// |            product and buffers results in a 2-entry skid queue that     |
// |            feeds mult3 over a valid/ready handshake. Also reports       |
// |            destination-register hazards for buffered multiplies.        |
// | Ports    :                                                               |
// |   clk_i                     clock, rising edge                           |
// |   rsn_i                     synchronous active-low reset                 |
// |   flush_i                   kill all buffered entries                    |
// |   mult2_valid_i / _ready_o  upstream handshake (ready from state only)   |
// |   mult2_pp_lo_i  [31:0]     a[15:0]*b[15:0]                              |
// |   mult2_pp_mid_i [32:0]     cross partial products                       |
// |   mult2_write_addr_i, _int_write_enable_i, _instruction_i, _pc_i         |
// |                             metadata carried with the product            |
// |   mult3_ready_i / mult3_valid_o  downstream handshake                    |
// |   mult3_*_o                 head entry, zero when the queue is empty     |
// |   mult2_hazard_addr_i       source register probed by issue              |
// |   mult2_hazard_o            a buffered entry will write that register    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mult2_stage (
   input  logic        clk_i,
   input  logic        rsn_i,
   input  logic        flush_i,
   // upstream (mult1 -> mult2 register)
   input  logic        mult2_valid_i,
   output logic        mult2_ready_o,
   input  logic [31:0] mult2_pp_lo_i,
   input  logic [32:0] mult2_pp_mid_i,
   input  logic [4:0]  mult2_write_addr_i,
   input  logic        mult2_int_write_enable_i,
   input  logic [31:0] mult2_instruction_i,
   input  logic [31:0] mult2_pc_i,
   // downstream (mult3)
   input  logic        mult3_ready_i,
   output logic        mult3_valid_o,
   output logic [31:0] mult3_int_write_data_o,
   output logic [4:0]  mult3_write_addr_o,
   output logic        mult3_int_write_enable_o,
   output logic [31:0] mult3_instruction_o,
   output logic [31:0] mult3_pc_o,
   // hazard probe
   input  logic [4:0]  mult2_hazard_addr_i,
   output logic        mult2_hazard_o
);

   localparam int    c_DEPTH     = 2;
   localparam logic [1:0] c_CNT_EMPTY = 2'd0;
   localparam logic [1:0] c_CNT_ONE   = 2'd1;
   localparam logic [1:0] c_CNT_FULL  = 2'd2;

   // ------------------------------------------------------------------
   // Queue state
   // ------------------------------------------------------------------
   logic [1:0]  r_count;
   logic        r_head;
   logic [31:0] r_result [c_DEPTH];
   logic [4:0]  r_addr   [c_DEPTH];
   logic        r_we     [c_DEPTH];
   logic [31:0] r_instr  [c_DEPTH];
   logic [31:0] r_pc     [c_DEPTH];

   // ------------------------------------------------------------------
   // Arithmetic: only pp_mid[15:0] can reach the low product word once
   // shifted up by 16; the upper mid bits belong to the high word.
   // ------------------------------------------------------------------
   logic [31:0] w_result;
   logic        w_unused_mid_hi;

   assign w_result        = mult2_pp_lo_i + {mult2_pp_mid_i[15:0], 16'h0000};
   assign w_unused_mid_hi = ^mult2_pp_mid_i[32:16];

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic w_valid;
   logic w_push;
   logic w_pop;
   logic w_tail;

   assign w_valid       = (r_count != c_CNT_EMPTY);
   assign mult2_ready_o = (r_count != c_CNT_FULL);
   assign w_push        = mult2_valid_i & mult2_ready_o;
   assign w_pop         = w_valid & mult3_ready_i;
   // First free slot: the head itself when empty, the other slot when one
   // entry is held. With a simultaneous pop at count 1 this is also the
   // slot the head advances to, so the new entry is presented next cycle.
   assign w_tail        = r_head ^ r_count[0];

   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         r_count <= c_CNT_EMPTY;
         r_head  <= 1'b0;
         for (int i = 0; i < c_DEPTH; i++) begin
            r_result[i] <= 32'h0;
            r_addr[i]   <= 5'h0;
            r_we[i]     <= 1'b0;
            r_instr[i]  <= 32'h0;
            r_pc[i]     <= 32'h0;
         end
      end else if (flush_i) begin
         // Stale payload is left in place; it is invisible once count is 0.
         r_count <= c_CNT_EMPTY;
         r_head  <= 1'b0;
      end else begin
         if (w_push) begin
            r_result[w_tail] <= w_result;
            r_addr[w_tail]   <= mult2_write_addr_i;
            r_we[w_tail]     <= mult2_int_write_enable_i;
            r_instr[w_tail]  <= mult2_instruction_i;
            r_pc[w_tail]     <= mult2_pc_i;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Head presentation, zeroed while empty
   // ------------------------------------------------------------------
   assign mult3_valid_o            = w_valid;
   assign mult3_int_write_data_o   = w_valid ? r_result[r_head] : 32'h0;
   assign mult3_write_addr_o       = w_valid ? r_addr[r_head]   : 5'h0;
   assign mult3_int_write_enable_o = w_valid & r_we[r_head];
   assign mult3_instruction_o      = w_valid ? r_instr[r_head]  : 32'h0;
   assign mult3_pc_o               = w_valid ? r_pc[r_head]     : 32'h0;

   // ------------------------------------------------------------------
   // Hazard: a slot is live when it is the head of a non-empty queue or
   // when the queue is full. Entries being accepted this cycle are not
   // yet live and are covered by the mult1 hazard.
   // ------------------------------------------------------------------
   logic [c_DEPTH-1:0] w_slot_hit;

   for (genvar g = 0; g < c_DEPTH; g++) begin : g_slot
      localparam logic c_IDX = 1'(g);
      logic w_slot_live;

      assign w_slot_live   = (r_count == c_CNT_FULL) |
                             ((r_count == c_CNT_ONE) & (r_head == c_IDX));
      assign w_slot_hit[g] = w_slot_live & r_we[g] &
                             (r_addr[g] == mult2_hazard_addr_i);
   end

   // Register x0 is hard-wired to zero and never creates a hazard.
   assign mult2_hazard_o = (mult2_hazard_addr_i != 5'h0) & (|w_slot_hit);

endmodule
`default_nettype wire

// File: tb/tb_mult2_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mult2_stage                                                |
// | Purpose  : Self-checking bench for mult2_stage. Stimulus pushes the      |
// |            hand-computed expected entry into a scoreboard queue; an     |
// |            independent monitor pops and compares on every mult3 pop.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mult2_stage;

   logic        clk_i = 1'b0;
   logic        rsn_i;
   logic        flush_i;
   logic        mult2_valid_i;
   logic        mult2_ready_o;
   logic [31:0] mult2_pp_lo_i;
   logic [32:0] mult2_pp_mid_i;
   logic [4:0]  mult2_write_addr_i;
   logic        mult2_int_write_enable_i;
   logic [31:0] mult2_instruction_i;
   logic [31:0] mult2_pc_i;
   logic        mult3_ready_i;
   logic        mult3_valid_o;
   logic [31:0] mult3_int_write_data_o;
   logic [4:0]  mult3_write_addr_o;
   logic        mult3_int_write_enable_o;
   logic [31:0] mult3_instruction_o;
   logic [31:0] mult3_pc_o;
   logic [4:0]  mult2_hazard_addr_i;
   logic        mult2_hazard_o;

   always #5 clk_i = ~clk_i;

   mult2_stage dut (
      .clk_i                    (clk_i),
      .rsn_i                    (rsn_i),
      .flush_i                  (flush_i),
      .mult2_valid_i            (mult2_valid_i),
      .mult2_ready_o            (mult2_ready_o),
      .mult2_pp_lo_i            (mult2_pp_lo_i),
      .mult2_pp_mid_i           (mult2_pp_mid_i),
      .mult2_write_addr_i       (mult2_write_addr_i),
      .mult2_int_write_enable_i (mult2_int_write_enable_i),
      .mult2_instruction_i      (mult2_instruction_i),
      .mult2_pc_i               (mult2_pc_i),
      .mult3_ready_i            (mult3_ready_i),
      .mult3_valid_o            (mult3_valid_o),
      .mult3_int_write_data_o   (mult3_int_write_data_o),
      .mult3_write_addr_o       (mult3_write_addr_o),
      .mult3_int_write_enable_o (mult3_int_write_enable_o),
      .mult3_instruction_o      (mult3_instruction_o),
      .mult3_pc_o               (mult3_pc_o),
      .mult2_hazard_addr_i      (mult2_hazard_addr_i),
      .mult2_hazard_o           (mult2_hazard_o)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        we;
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t sb[$];
   int     errors = 0;
   int     checks = 0;

   // streaming vectors with hand-computed low product words
   logic [31:0] s_lo  [8] = '{32'h0000_0001, 32'h0000_FFFF, 32'h8000_0000, 32'h0002_0000,
                              32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0F0F_0F0F};
   logic [32:0] s_mid [8] = '{33'h0_0000_0000, 33'h0_0000_0001, 33'h0_0000_8000, 33'h1_0000_FFFF,
                              33'h0_2222_3333, 33'h0_0000_0000, 33'h0_FFFF_0007, 33'h1_F0F0_1010};
   logic [31:0] s_exp [8] = '{32'h0000_0001, 32'h0001_FFFF, 32'h0000_0000, 32'h0001_0000,
                              32'h4444_1111, 32'hDEAD_BEEF, 32'h0007_0000, 32'h1F1F_0F0F};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   // Drive one entry and hold it until accepted (bounded).
   task automatic send(input logic [31:0] lo, input logic [32:0] mid, input logic [4:0] addr,
                       input logic we, input logic [31:0] pc, input logic [31:0] exp_data);
      bit   accepted;
      logic rdy;
      entry_t e;
      mult2_pp_lo_i            = lo;
      mult2_pp_mid_i           = mid;
      mult2_write_addr_i       = addr;
      mult2_int_write_enable_i = we;
      mult2_pc_i               = pc;
      mult2_instruction_i      = {pc[23:0], 8'h33};
      mult2_valid_i            = 1'b1;
      accepted = 1'b0;
      for (int n = 0; n < 20 && !accepted; n++) begin
         rdy = mult2_ready_o;
         @(posedge clk_i);
         #1;
         if (rdy) accepted = 1'b1;
      end
      mult2_valid_i = 1'b0;
      if (accepted) begin
         e.data  = exp_data;
         e.addr  = addr;
         e.we    = we;
         e.instr = {pc[23:0], 8'h33};
         e.pc    = pc;
         sb.push_back(e);
      end else begin
         checks++;
         errors++;
         $display("FAIL send_timeout: pc %h not accepted, got ready=%b required 1", pc, mult2_ready_o);
      end
   endtask

   task automatic drain(input string nm);
      for (int n = 0; n < 10 && sb.size() != 0; n++) begin
         @(posedge clk_i);
         #1;
      end
      chk(nm, sb.size(), 0);
   endtask

   // Monitor: compares every pop against the scoreboard, and checks that
   // the data outputs are zero whenever nothing is presented.
   entry_t m_got;
   entry_t m_exp;
   initial begin
      forever begin
         @(negedge clk_i);
         if (rsn_i) begin
            m_got = {mult3_int_write_data_o, mult3_write_addr_o, mult3_int_write_enable_o,
                     mult3_instruction_o, mult3_pc_o};
            if (mult3_valid_o && mult3_ready_i) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL pop_unexpected: got %h required no entry", m_got);
               end else begin
                  m_exp = sb.pop_front();
                  if (m_got !== m_exp) begin
                     errors++;
                     $display("FAIL pop_entry: got %h required %h", m_got, m_exp);
                  end
               end
            end else if (!mult3_valid_o) begin
               checks++;
               if (m_got !== '0) begin
                  errors++;
                  $display("FAIL idle_outputs: got %h required 0", m_got);
               end
            end
         end
      end
   end

   initial begin
      rsn_i = 1'b0;  flush_i = 1'b0;  mult2_valid_i = 1'b0;
      mult2_pp_lo_i = '0;  mult2_pp_mid_i = '0;  mult2_write_addr_i = '0;
      mult2_int_write_enable_i = 1'b0;  mult2_instruction_i = '0;  mult2_pc_i = '0;
      mult3_ready_i = 1'b0;  mult2_hazard_addr_i = 5'd5;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_valid", mult3_valid_o, 0);
      chk("rst_ready", mult2_ready_o, 1);
      chk("rst_hazard", mult2_hazard_o, 0);
      chk("rst_data", mult3_int_write_data_o, 0);
      rsn_i = 1'b1;

      // single op, one-cycle latency then empty
      mult3_ready_i = 1'b1;
      send(32'h0000_0006, 33'h0_0000_0001, 5'd5, 1'b1, 32'h80, 32'h0001_0006);
      chk("single_valid", mult3_valid_o, 1);
      chk("single_data", mult3_int_write_data_o, 32'h0001_0006);
      chk("single_addr", mult3_write_addr_o, 5);
      chk("single_we", mult3_int_write_enable_o, 1);
      @(posedge clk_i);
      #1;
      chk("single_after_valid", mult3_valid_o, 0);
      chk("single_after_data", mult3_int_write_data_o, 0);

      // wrap-around, upper mid bits ignored
      send(32'hFFFF_FFFF, 33'h1_8000_0001, 5'd3, 1'b1, 32'h84, 32'h0000_FFFF);
      chk("wrap_data", mult3_int_write_data_o, 32'h0000_FFFF);
      @(posedge clk_i);
      #1;

      // backpressure: A, B fill the queue, C is held
      mult3_ready_i = 1'b0;
      send(32'h0000_0010, 33'h0_0000_0002, 5'd1, 1'b1, 32'h100, 32'h0002_0010);
      send(32'h1234_5678, 33'h0_0000_0001, 5'd2, 1'b1, 32'h104, 32'h1235_5678);
      chk("bp_full_ready", mult2_ready_o, 0);
      mult2_pp_lo_i = 32'h0; mult2_pp_mid_i = 33'h1_FFFF_ABCD; mult2_pc_i = 32'h108;
      mult2_valid_i = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk_i);
         #1;
         chk("bp_hold_ready", mult2_ready_o, 0);
         chk("bp_hold_head", mult3_pc_o, 32'h100);
      end
      mult3_ready_i = 1'b1;
      #1;
      chk("bp_ready_not_comb", mult2_ready_o, 0);
      send(32'h0000_0000, 33'h1_FFFF_ABCD, 5'd4, 1'b0, 32'h108, 32'hABCD_0000);
      drain("bp_drain");

      // streaming at count 1: one result per cycle, issue order
      for (int i = 0; i < 8; i++) begin
         send(s_lo[i], s_mid[i], 5'(i + 10), 1'(i), 32'h200 + 32'(4 * i), s_exp[i]);
         chk("stream_valid", mult3_valid_o, 1);
         chk("stream_ready", mult2_ready_o, 1);
         chk("stream_pc", mult3_pc_o, 32'h200 + 32'(4 * i));
      end
      drain("stream_drain");

      // flush with a same-cycle push: nothing survives
      mult3_ready_i = 1'b0;
      send(32'h1, 33'h0, 5'd7, 1'b1, 32'h300, 32'h1);
      send(32'h2, 33'h0, 5'd8, 1'b1, 32'h304, 32'h2);
      chk("flush_full_ready", mult2_ready_o, 0);
      mult2_pc_i = 32'hDEAD0; mult2_write_addr_i = 5'd7; mult2_valid_i = 1'b1;
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      mult2_valid_i = 1'b0;
      sb.delete();
      mult2_hazard_addr_i = 5'd7;
      #1;
      chk("flush_valid", mult3_valid_o, 0);
      chk("flush_ready", mult2_ready_o, 1);
      chk("flush_hazard", mult2_hazard_o, 0);
      mult3_ready_i = 1'b1;
      send(32'h0000_0003, 33'h0_0000_0003, 5'd6, 1'b1, 32'h310, 32'h0003_0003);
      drain("flush_recover");

      // hazard probing, then reset mid-stream
      mult3_ready_i = 1'b0;
      send(32'h5, 33'h0, 5'd7, 1'b1, 32'h400, 32'h5);
      send(32'h6, 33'h0, 5'd9, 1'b0, 32'h404, 32'h6);
      mult2_hazard_addr_i = 5'd7;
      #1;
      chk("hazard_7", mult2_hazard_o, 1);
      mult2_hazard_addr_i = 5'd9;
      #1;
      chk("hazard_9_no_we", mult2_hazard_o, 0);
      mult2_hazard_addr_i = 5'd0;
      #1;
      chk("hazard_x0", mult2_hazard_o, 0);
      mult2_hazard_addr_i = 5'd7;
      rsn_i = 1'b0;
      @(posedge clk_i);
      #1;
      sb.delete();
      chk("rst_mid_valid", mult3_valid_o, 0);
      chk("rst_mid_data", mult3_int_write_data_o, 0);
      chk("rst_mid_pc", mult3_pc_o, 0);
      chk("rst_mid_instr", mult3_instruction_o, 0);
      chk("rst_mid_addr", mult3_write_addr_o, 0);
      chk("rst_mid_we", mult3_int_write_enable_o, 0);
      chk("rst_mid_hazard", mult2_hazard_o, 0);
      chk("rst_mid_ready", mult2_ready_o, 1);
      rsn_i = 1'b1;
      mult3_ready_i = 1'b1;
      send(32'h0000_0100, 33'h0_0000_0010, 5'd11, 1'b1, 32'h500, 32'h0010_0100);
      drain("final_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
